// File: rtl/barrel_shift_pkg.sv
// Shared types for the barrel shift scheduler.
// Holds shift ops, scheduler states and a shamt width helper.
package barrel_shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } sched_state_t;

  function automatic int shamt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/barrel_shift_core.sv
// Combinational log-stage shifter: one 2^k stage per shamt bit.
// Ports: data/shamt/op in, result out. Rotate needs BARREL_SHIFT_ROTATE_EN.
module barrel_shift_core
  import barrel_shift_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]         data,
  input  logic [$clog2(DATA_WIDTH)-1:0] shamt,
  input  shift_op_t                     op,
  output logic [DATA_WIDTH-1:0]         result
);

  localparam int SW = shamt_width(DATA_WIDTH);

  logic [SW:0][DATA_WIDTH-1:0] stg;

  assign stg[0] = data;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int S = 1 << k;
    logic [DATA_WIDTH-1:0] cur;
    logic [DATA_WIDTH-1:0] nxt;

    assign cur = stg[k];

    // Arithmetic fill stays correct per stage: the MSB never changes
    // across SRA stages, so each stage sees the operand's sign.
    always_comb begin
      nxt = cur << S;
      unique case (op)
        OP_SRL: nxt = cur >> S;
        OP_SRA: nxt = $signed(cur) >>> S;
`ifdef BARREL_SHIFT_ROTATE_EN
        OP_ROL: nxt = (cur << S) | (cur >> (DATA_WIDTH - S));
`endif
        default: nxt = cur << S;
      endcase
    end

    assign stg[k+1] = shamt[k] ? nxt : cur;
  end

  assign result = stg[SW];

endmodule

// File: rtl/barrel_shift_scheduler.sv
// Round-robin scheduler sharing one barrel shifter among NUM_REQ lanes.
// Ports: req_* handshake in, rsp_* handshake out, busy. Macro: BARREL_SHIFT_ROTATE_EN.
module barrel_shift_scheduler
  import barrel_shift_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                        clk,
  input  logic                                        rstN,
  input  logic [NUM_REQ-1:0]                          req_valid,
  output logic [NUM_REQ-1:0]                          req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]          req_data,
  input  logic [NUM_REQ-1:0][$clog2(DATA_WIDTH)-1:0]  req_shamt,
  input  logic [NUM_REQ-1:0][1:0]                     req_op,
  output logic                                        rsp_valid,
  input  logic                                        rsp_ready,
  output logic [DATA_WIDTH-1:0]                       rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]                  rsp_id,
  output logic                                        busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int SW  = shamt_width(DATA_WIDTH);

  sched_state_t          state;
  logic [IDW-1:0]        last_grant;
  logic [DATA_WIDTH-1:0] data_q;
  logic [SW-1:0]         shamt_q;
  shift_op_t             op_q;
  logic [IDW-1:0]        id_q;
  logic [DATA_WIDTH-1:0] core_out;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;
  logic           accept_en;
  logic           accept;

  // Search starts one past the last winner and wraps.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // DONE with rsp_ready accepts in the same cycle for back-to-back ops.
  assign accept_en = (state == IDLE) ||
                     (state == DONE && rsp_ready);
  assign accept    = accept_en && gnt_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  barrel_shift_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .data  (data_q),
    .shamt (shamt_q),
    .op    (op_q),
    .result(core_out)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      last_grant <= IDW'(NUM_REQ - 1);
      data_q     <= '0;
      shamt_q    <= '0;
      op_q       <= OP_SLL;
      id_q       <= '0;
    end else if (accept) begin
      last_grant <= gnt_idx;
      data_q     <= req_data[gnt_idx];
      shamt_q    <= req_shamt[gnt_idx];
      op_q       <= shift_op_t'(req_op[gnt_idx]);
      id_q       <= gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) state <= SHIFT;
        end
        SHIFT: begin
          rsp_data <= core_out;
          rsp_id   <= id_q;
          state    <= DONE;
        end
        DONE: begin
          if (rsp_ready) state <= accept ? SHIFT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_shift_scheduler.sv
// Self-checking bench for barrel_shift_scheduler.
// Table of single-op vectors plus round-robin, stall and reset sequences.
module tb_barrel_shift_scheduler;

  logic            clk;
  logic            rstN;
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic [3:0][7:0] req_data;
  logic [3:0][2:0] req_shamt;
  logic [3:0][1:0] req_op;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [7:0]      rsp_data;
  logic [1:0]      rsp_id;
  logic            busy;

  int errors = 0;
  int checks = 0;

  barrel_shift_scheduler #(
    .NUM_REQ   (4),
    .DATA_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .req_shamt(req_shamt),
    .req_op   (req_op),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_id   (rsp_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [2:0] shamt;
    logic [1:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [11];
  logic [7:0] rr_exp [4];

  initial begin
    vecs[0]  = '{8'h81, 3'd3, 2'b00, 8'h08};
    vecs[1]  = '{8'h90, 3'd2, 2'b10, 8'hE4};
    vecs[2]  = '{8'h90, 3'd2, 2'b01, 8'h24};
    vecs[3]  = '{8'h90, 3'd0, 2'b00, 8'h90};
    vecs[4]  = '{8'h90, 3'd0, 2'b10, 8'h90};
`ifdef BARREL_SHIFT_ROTATE_EN
    vecs[5]  = '{8'h81, 3'd1, 2'b11, 8'h03};
    vecs[9]  = '{8'hA5, 3'd4, 2'b11, 8'h5A};
`else
    vecs[5]  = '{8'h81, 3'd1, 2'b11, 8'h02};
    vecs[9]  = '{8'hA5, 3'd4, 2'b11, 8'h50};
`endif
    vecs[6]  = '{8'hFF, 3'd7, 2'b01, 8'h01};
    vecs[7]  = '{8'h80, 3'd7, 2'b10, 8'hFF};
    vecs[8]  = '{8'h01, 3'd7, 2'b00, 8'h80};
    vecs[10] = '{8'h7F, 3'd3, 2'b10, 8'h0F};

    rr_exp[0] = 8'h02;
    rr_exp[1] = 8'h21;
    rr_exp[2] = 8'hC8;
    rr_exp[3] = 8'h3C;

    rstN      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_shamt = '0;
    req_op    = '0;
    rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data",  32'(rsp_data),  0);
    chk("rst_rsp_id",    32'(rsp_id),    0);
    chk("rst_busy",      32'(busy),      0);
    rstN = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      int r;
      r = i % 4;
      req_valid    = 4'(1 << r);
      req_data[r]  = vecs[i].data;
      req_shamt[r] = vecs[i].shamt;
      req_op[r]    = vecs[i].op;
      @(negedge clk);
      chk($sformatf("v%0d_grant", i), 32'(req_ready), 32'(1 << r));
      chk($sformatf("v%0d_idle", i), 32'(busy), 0);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk($sformatf("v%0d_shift_busy", i), 32'(busy), 1);
      chk($sformatf("v%0d_shift_nrsp", i), 32'(rsp_valid), 0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 1);
      chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].exp));
      chk($sformatf("v%0d_rsp_id", i), 32'(rsp_id), 32'(r));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_back_idle", i), 32'(busy), 0);
    end

    // Round robin with all lanes pending, starting from a fresh reset.
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;
    req_data  = {8'h0F, 8'h90, 8'h42, 8'h81};
    req_shamt = {3'd2, 3'd1, 3'd1, 3'd1};
    req_op    = {2'b00, 2'b10, 2'b01, 2'b00};
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rr_first_grant", 32'(req_ready), 1);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d_shift_nogrant", n), 32'(req_ready), 0);
      chk($sformatf("rr%0d_shift_nrsp", n), 32'(rsp_valid), 0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d_rsp_valid", n), 32'(rsp_valid), 1);
      chk($sformatf("rr%0d_rsp_id", n), 32'(rsp_id), 32'(n % 4));
      chk($sformatf("rr%0d_rsp_data", n), 32'(rsp_data), 32'(rr_exp[n % 4]));
      chk($sformatf("rr%0d_next_grant", n), 32'(req_ready),
          32'(1 << ((n + 1) % 4)));
    end

    // Stall the consumer: response holds, nobody is granted.
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stall%0d_valid", c), 32'(rsp_valid), 1);
      chk($sformatf("stall%0d_data", c), 32'(rsp_data), 32'(rr_exp[0]));
      chk($sformatf("stall%0d_id", c), 32'(rsp_id), 0);
      chk($sformatf("stall%0d_ready", c), 32'(req_ready), 0);
      chk($sformatf("stall%0d_busy", c), 32'(busy), 1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("release_grant", 32'(req_ready), 32'b0010);

    // Requester 1 accepted; reset while its shift is in flight.
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("pre_rst_busy", 32'(busy), 1);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    chk("midrst_busy",      32'(busy),      0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_rsp_data",  32'(rsp_data),  0);
    chk("midrst_rsp_id",    32'(rsp_id),    0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d_nrsp", c), 32'(rsp_valid), 0);
    end
    req_valid = 4'hF;
    #1;
    chk("postrst_grant0", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/barrel_shift_scheduler.md
# barrel_shift_scheduler

Round-robin scheduler that shares one barrel shifter between `NUM_REQ` requesters. Each requester submits a shift request over a valid/ready handshake. The scheduler grants one request at a time, latches its operands and sequences the shift through a registered shifter core. It returns the result with the requester ID on a single valid/ready response port. The block sits between the per-lane shift requesters and the single shifter datapath, so the datapath never sees a conflict.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 8, operand width (power of two, ≥4)
- `clk` in 1: single clock; all state updates on the rising edge
- `rstN` in 1: asynchronous, active-low reset
- `req_valid` in `[NUM_REQ-1:0]`: request valid per requester
- `req_ready` out `[NUM_REQ-1:0]`: grant/accept per requester; at most one bit set
- `req_data` in `[NUM_REQ-1:0][DATA_WIDTH-1:0]`: operand per requester
- `req_shamt` in `[NUM_REQ-1:0][$clog2(DATA_WIDTH)-1:0]`: shift amount
- `req_op` in `[NUM_REQ-1:0][1:0]`: 00 SLL, 01 SRL, 10 SRA, 11 ROL
- `rsp_valid` out 1: result valid
- `rsp_ready` in 1: consumer accepts the result
- `rsp_data` out `DATA_WIDTH`: shifted result
- `rsp_id` out `$clog2(NUM_REQ)`: index of the requester that owns `rsp_data`
- `busy` out 1: an operation is latched or awaiting response

## Operation
- FSM states IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE:** round-robin arbitration over `req_valid`.
  - Search starts at `last_grant+1` and wraps modulo `NUM_REQ`.
  - The winner gets `req_ready[i]=1` in the same cycle. This is combinational from `req_valid`.
  - On accept: latch data, shamt, op and id into operand registers, set `last_grant=i`, and go to SHIFT.
  - No valid request: stay in IDLE with all `req_ready` low.
- **SHIFT:** the shifter core computes from the operand registers. The result is registered into `rsp_data`/`rsp_id` and the FSM goes to DONE. `req_ready` is all zero.
- **DONE:** `rsp_valid=1`. `rsp_data` and `rsp_id` stay stable until `rsp_ready`.
  - `rsp_ready=1` with a pending request: arbitration runs in the same cycle, the new request is accepted, and the FSM goes directly to SHIFT. This is back-to-back operation.
  - `rsp_ready=1` with no pending request: go to IDLE.
- `last_grant` resets to `NUM_REQ-1`, so requester 0 has first priority after reset. It updates only on an accepted request.
- Requesters must hold `req_valid`, data, shamt and op stable until accepted. Dropping valid before `req_ready` withdraws the request; no state changes.
- Arithmetic rules:
  - Result is always `DATA_WIDTH` bits.
  - SLL/SRL fill with zeros; SRA fills with the operand MSB.
  - `shamt=0` returns the operand unchanged.
  - Bits shifted out are discarded; there is no overflow flag.
- `busy=1` in SHIFT and DONE, and 0 in IDLE.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`, `busy=0`, FSM in IDLE, `last_grant=NUM_REQ-1`.
- Latency: request accepted at edge t, `rsp_valid` asserted after edge t+1, i.e. 2 cycles from acceptance.
- Throughput:
  - One result per 2 cycles when the consumer holds `rsp_ready=1` and requests are always pending.
  - A stalled `rsp_ready` backpressures all requesters.
- Reset mid-operation: any state returns to IDLE immediately. The latched operation is lost and no response is produced.
- Simultaneous valids: exactly one grant per accept cycle, and never two `req_ready` bits in the same cycle.

## Configuration
- `BARREL_SHIFT_ROTATE_EN`
  - Defined: op 11 performs rotate-left by shamt.
  - Undefined: op 11 decodes as SLL and the rotate logic is absent from the core.

## Structure
- Package `barrel_shift_pkg` holds:
  - the `shift_op_t` enum (SLL, SRL, SRA, ROL)
  - the `sched_state_t` enum (IDLE, SHIFT, DONE)
  - a `shamt_width` helper function
- Sub-module `barrel_shift_core` is a combinational log-stage shifter: cascaded 2^k stages, one per shamt bit, with op-dependent fill.
  - The scheduler instantiates it once and registers its output.

## Test plan
- Reset, then `req_valid=4'b0001`, data 8'h81, SLL, shamt 3 → `req_ready[0]` same cycle; `rsp_valid` 2 cycles later with `rsp_data=8'h08`, `rsp_id=0`.
- All four requesters valid continuously, `rsp_ready=1` → grants in order 0,1,2,3,0; one response every 2 cycles; IDs match.
- SRA on 8'h90 by 2 → 8'hE4. SRL on 8'h90 by 2 → 8'h24. shamt 0 → 8'h90.
- Response held with `rsp_ready=0` for 5 cycles → `rsp_data`/`rsp_id` stable, all `req_ready` low, `busy=1`; release → accept next request the same cycle.
- `rstN` pulsed low while in SHIFT → outputs at reset values immediately; no response; next grant goes to requester 0.
- op 11 on 8'h81 by 1 → 8'h03 with `BARREL_SHIFT_ROTATE_EN` defined, 8'h02 without.
